// File: rtl/display_sequencer.sv
// MAX7219 transaction sequencer: configuration burst after reset, then display refreshes,
// with periodic/forced re-configuration, update coalescing and ack-timeout retry.
module display_sequencer #(
    parameter int NUM_CFG      = 5,
    parameter int REFRESH_SECS = 60,
    parameter int ACK_TIMEOUT  = 1024,
    parameter int MAX_RETRY    = 3,
    parameter int IDX_W        = $clog2(NUM_CFG)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_1hz_stb,
    input  logic             i_clk_set_stb,
    input  logic             i_clk_set,
    input  logic             i_force_cfg_stb,
    output logic             o_display_stb,
    input  logic             i_display_ack,
    output logic             o_write_config,
    output logic [IDX_W-1:0] o_cfg_idx,
    output logic             o_busy,
    output logic             o_err_stb
);
    localparam int TO_W  = $clog2(ACK_TIMEOUT);
    localparam int RT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int SEC_W = (REFRESH_SECS > 1) ? $clog2(REFRESH_SECS) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CFG - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [RT_W-1:0]  RT_LAST  = RT_W'(MAX_RETRY);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(REFRESH_SECS - 1);

    typedef enum logic [1:0] {IDLE, CONFIG, UPDATE} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             stb, stb_nxt;
    logic [TO_W-1:0]  to_cnt, to_nxt;
    logic [RT_W-1:0]  retry, retry_nxt;
    logic [SEC_W-1:0] sec_cnt, sec_nxt;
    logic             upd_pend, upd_nxt;
    logic             cfg_pend, cfg_nxt;
    logic             err, err_nxt;
    logic             upd_event, ack, cfg_req, burst_start, upd_issue;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state    <= CONFIG;
            idx      <= '0;
            stb      <= 1'b1;
            to_cnt   <= '0;
            retry    <= '0;
            sec_cnt  <= '0;
            upd_pend <= 1'b1;
            cfg_pend <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            stb      <= stb_nxt;
            to_cnt   <= to_nxt;
            retry    <= retry_nxt;
            sec_cnt  <= sec_nxt;
            upd_pend <= upd_nxt;
            cfg_pend <= cfg_nxt;
            err      <= err_nxt;
        end
    end

    always_comb begin
        upd_event   = i_clk_set ? i_clk_set_stb : i_1hz_stb;
        ack         = stb & i_display_ack;
        state_nxt   = state;
        idx_nxt     = idx;
        stb_nxt     = stb;
        to_nxt      = to_cnt;
        retry_nxt   = retry;
        sec_nxt     = sec_cnt;
        err_nxt     = 1'b0;
        cfg_req     = i_force_cfg_stb;
        burst_start = 1'b0;
        upd_issue   = 1'b0;

        if (REFRESH_SECS > 0 && i_1hz_stb) begin
            if (sec_cnt == SEC_LAST) begin
                sec_nxt = '0;
                cfg_req = 1'b1;
            end else begin
                sec_nxt = sec_cnt + 1'b1;
            end
        end

        if (state == IDLE) begin
            if (cfg_pend) begin
                state_nxt   = CONFIG;
                idx_nxt     = '0;
                stb_nxt     = 1'b1;
                burst_start = 1'b1;
            end else if (upd_pend || upd_event) begin
                state_nxt = UPDATE;
                stb_nxt   = 1'b1;
                upd_issue = 1'b1;
            end
        end else if (!stb) begin
            // end of the one-cycle gap after an ack or a timeout
            stb_nxt   = 1'b1;
            upd_issue = (state == UPDATE);
        end else if (ack) begin
            stb_nxt   = 1'b0;
            to_nxt    = '0;
            retry_nxt = '0;
            if (state == UPDATE) begin
                state_nxt = IDLE;
            end else if (idx == LAST_IDX) begin
                state_nxt = UPDATE;
                idx_nxt   = '0;
            end else begin
                idx_nxt = idx + 1'b1;
            end
        end else if (to_cnt == TO_LAST) begin
            stb_nxt = 1'b0;
            to_nxt  = '0;
            if (retry == RT_LAST) begin
                // give up; force a fresh configuration so the display recovers
                err_nxt   = 1'b1;
                state_nxt = IDLE;
                idx_nxt   = '0;
                retry_nxt = '0;
                cfg_req   = 1'b1;
            end else begin
                retry_nxt = retry + 1'b1;
            end
        end else begin
            to_nxt = to_cnt + 1'b1;
        end

        if (burst_start) sec_nxt = '0;
        cfg_nxt = burst_start ? 1'b0 : (cfg_pend | cfg_req);
        upd_nxt = upd_issue ? 1'b0 : (burst_start | upd_pend | upd_event);
    end

    assign o_display_stb  = stb;
    assign o_write_config = (state == CONFIG);
    assign o_cfg_idx      = idx;
    assign o_busy         = (state != IDLE);
    assign o_err_stb      = err;

endmodule
